// File: rtl/pkg_en.sv
// Shared ElectronNest token types and widths used by the external-memory bridge.
package pkg_en;
  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 32;

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

// File: rtl/ext_mem_bridge_if.sv
// Bus bundle between ElectronNest load/store ports, the bridge and its BRAM.
// master = bridge side, slave = system/BRAM side.
interface ext_mem_bridge_if #(
  parameter int DEPTH_MEM = 1024
);
  localparam int AW = $clog2(DEPTH_MEM);

  logic                                I_Boot;
  logic                                O_Boot;
  logic                                I_Ld_Req;
  logic [pkg_en::WIDTH_EXADDR-1:0]     I_Ld_Addr;
  pkg_en::FTk_t                        O_Ld_FTk;
  pkg_en::BTk_t                        I_Ld_BTk;
  logic                                I_St_Req;
  logic [pkg_en::WIDTH_EXADDR-1:0]     I_St_Addr;
  pkg_en::FTk_t                        I_St_FTk;
  pkg_en::BTk_t                        O_St_BTk;
  logic                                O_Mem_En;
  logic                                O_Mem_We;
  logic [AW-1:0]                       O_Mem_Addr;
  logic [pkg_en::WIDTH_DATA-1:0]       O_Mem_WData;
  logic [pkg_en::WIDTH_DATA-1:0]       I_Mem_RData;

  modport master (
    input  I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    output O_Boot, O_Ld_FTk, O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData
  );

  modport slave (
    output I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    input  O_Boot, O_Ld_FTk, O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData
  );
endinterface

// File: rtl/ext_mem_bridge.sv
// Bridge from ElectronNest load/store ports to a 1-cycle-latency single-port BRAM:
// boot stream (pad + config words), then load/store service through a 2-deep token FIFO.
module ext_mem_bridge #(
  parameter int DEPTH_MEM = 1024,
  parameter int BOOT_PAD  = 3,
  parameter int BOOT_LEN  = 5
) (
  input  logic             clock,
  input  logic             reset,
  ext_mem_bridge_if.master bus
);
  import pkg_en::*;

  localparam int AW = $clog2(DEPTH_MEM);
  localparam int PW = $clog2(BOOT_PAD + 1);
  localparam int LW = $clog2(BOOT_LEN + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PAD, ST_CFG, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           pad_cnt_q, pad_cnt_d;
  logic [LW-1:0]           cfg_cnt_q, cfg_cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [WIDTH_EXADDR-1:0] rd_tag_q, rd_tag_d;
  FTk_t                    fifo_q [2];
  FTk_t                    fifo_d [2];
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              count_q, count_d;

  logic                    boot_go, pad_phase, pad_push, pad_last;
  logic                    pop, push, cfg_read, ld_accept, st_write, st_nack;
  logic [1:0]              occ_next;
  FTk_t                    push_tok;
  logic                    mem_en, mem_we;
  logic [AW-1:0]           mem_addr;
  logic [WIDTH_DATA-1:0]   mem_wdata;
  BTk_t                    st_btk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pad_cnt_q <= '0;
      cfg_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= '0;
      for (int k = 0; k < 2; k++) fifo_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pad_cnt_q <= pad_cnt_d;
      cfg_cnt_q <= cfg_cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      for (int k = 0; k < 2; k++) fifo_q[k] <= fifo_d[k];
    end
  end

  always_comb begin
    state_d   = state_q;
    pad_cnt_d = pad_cnt_q;
    cfg_cnt_d = cfg_cnt_q;
    rd_pend_d = 1'b0;
    rd_tag_d  = rd_tag_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fifo_d    = fifo_q;
    push_tok  = '0;
    cfg_read  = 1'b0;
    ld_accept = 1'b0;
    st_write  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    // The first pad is pushed in the I_Boot cycle itself so it is visible one cycle later.
    boot_go   = (state_q == ST_IDLE) && bus.I_Boot && !reset;
    pad_phase = boot_go || (state_q == ST_PAD);
    pop       = (count_q != 2'd0) && !bus.I_Ld_BTk.n;
    pad_push  = pad_phase && ((count_q != 2'd2) || pop);
    pad_last  = pad_push && (pad_cnt_q == PW'(BOOT_PAD - 1));
    push      = pad_push || rd_pend_q;
    occ_next  = count_q - {1'b0, pop} + {1'b0, push};

    if (pad_push) begin
      push_tok.v = 1'b1;
      push_tok.a = (pad_cnt_q == '0);
      pad_cnt_d  = pad_cnt_q + PW'(1);
    end else if (rd_pend_q) begin
      push_tok.v = 1'b1;
      push_tok.i = rd_tag_q;
      push_tok.d = bus.I_Mem_RData;
    end

    // A read is only issued when its data is sure to find a free FIFO slot next cycle,
    // counting this cycle's pop and push, so BRAM data never has to be held.
    cfg_read  = (pad_last || (state_q == ST_CFG)) && (cfg_cnt_q < LW'(BOOT_LEN))
                && (occ_next < 2'd2);
    ld_accept = (state_q == ST_RUN) && bus.I_Ld_Req && (occ_next < 2'd2);
    st_write  = (state_q == ST_RUN) && bus.I_St_Req && bus.I_St_FTk.v && !ld_accept;

    if (cfg_read) begin
      mem_en    = 1'b1;
      mem_addr  = AW'(cfg_cnt_q);
      rd_pend_d = 1'b1;
      rd_tag_d  = '0;
      cfg_cnt_d = cfg_cnt_q + LW'(1);
    end else if (ld_accept) begin
      mem_en    = 1'b1;
      mem_addr  = bus.I_Ld_Addr[AW-1:0];
      rd_pend_d = 1'b1;
      rd_tag_d  = bus.I_Ld_Addr;
    end else if (st_write) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = bus.I_St_Addr[AW-1:0];
      mem_wdata = bus.I_St_FTk.d;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = push_tok;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = occ_next;

    case (state_q)
      ST_IDLE: if (boot_go) state_d = pad_last ? ST_CFG : ST_PAD;
      ST_PAD:  if (pad_last) state_d = ST_CFG;
      ST_CFG:  if ((cfg_cnt_q == LW'(BOOT_LEN)) && !rd_pend_q) state_d = ST_RUN;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    st_nack  = bus.I_St_Req && !st_write && !reset;
    st_btk   = '0;
    st_btk.n = st_nack;
  end

  assign bus.O_Boot      = (state_q == ST_PAD) || (state_q == ST_CFG);
  assign bus.O_Ld_FTk    = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
  assign bus.O_St_BTk    = st_btk;
  assign bus.O_Mem_En    = mem_en;
  assign bus.O_Mem_We    = mem_we;
  assign bus.O_Mem_Addr  = mem_addr;
  assign bus.O_Mem_WData = mem_wdata;

  logic unused_bits;
  assign unused_bits = ^{bus.I_Ld_BTk.t, bus.I_Ld_BTk.v, bus.I_Ld_BTk.c,
                         bus.I_St_FTk.a, bus.I_St_FTk.r, bus.I_St_FTk.c, bus.I_St_FTk.i,
                         bus.I_St_Addr[WIDTH_EXADDR-1:AW]};
endmodule

// File: tb/tb_ext_mem_bridge.sv
// Scoreboard bench for ext_mem_bridge: expected tokens are queued as stimulus is driven
// and popped by a monitor whenever the DUT hands a token over (v=1, n=0).
module tb_ext_mem_bridge;
  import pkg_en::*;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] d;
    logic [31:0] i;
    logic        a;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  int          n_vec  = 0;
  int          n_miss = 0;
  exp_t        exp_q[$];
  logic [31:0] bram [DEPTH];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] cfg_words [5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

  always #5 clock = ~clock;

  ext_mem_bridge_if #(.DEPTH_MEM(DEPTH)) bus ();

  ext_mem_bridge #(.DEPTH_MEM(DEPTH), .BOOT_PAD(3), .BOOT_LEN(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // BRAM model: one-cycle read latency, read-first.
  always @(posedge clock) begin
    if (pre_we) bram[pre_addr] <= pre_data;
    else if (bus.O_Mem_En && bus.O_Mem_We) bram[bus.O_Mem_Addr] <= bus.O_Mem_WData;
    if (bus.O_Mem_En && !bus.O_Mem_We) bus.I_Mem_RData <= bram[bus.O_Mem_Addr];
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(posedge clock); #1;
    pre_we = 1'b1; pre_addr = a[9:0]; pre_data = d;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic push_boot_expect();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.d = 0; e.i = 0; e.a = (k == 0);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      e.d = cfg_words[k]; e.i = 0; e.a = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.O_Ld_FTk.v === 1'b1 && bus.I_Ld_BTk.n === 1'b0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL sb_unexpected: got d=%h i=%0d, required no token", bus.O_Ld_FTk.d, bus.O_Ld_FTk.i);
        end else begin
          e = exp_q.pop_front();
          if (bus.O_Ld_FTk.d !== e.d || bus.O_Ld_FTk.i !== e.i || bus.O_Ld_FTk.a !== e.a) begin
            n_miss++;
            $display("FAIL sb_token: got d=%h i=%0d a=%0b, required d=%h i=%0d a=%0b",
                     bus.O_Ld_FTk.d, bus.O_Ld_FTk.i, bus.O_Ld_FTk.a, e.d, e.i, e.a);
          end else begin
            $display("tok d=%h i=%0d a=%0b ok", e.d, e.i, e.a);
          end
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.I_St_Req = 1'b1;
    @(negedge clock);
    n_vec++;
    if (bus.O_Boot !== 1'b0 || bus.O_Ld_FTk !== '0) begin
      n_miss++;
      $display("FAIL reset_out: got boot=%b tok=%h, required 0", bus.O_Boot, bus.O_Ld_FTk);
    end
    n_vec++;
    if (bus.O_St_BTk !== '0 || bus.O_Mem_En !== 1'b0 || bus.O_Mem_We !== 1'b0
        || bus.O_Mem_Addr !== '0 || bus.O_Mem_WData !== '0) begin
      n_miss++;
      $display("FAIL reset_mem: got btk=%h en=%b we=%b addr=%h wd=%h, required 0",
               bus.O_St_BTk, bus.O_Mem_En, bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (bus.O_St_BTk.n !== 1'b1) begin
      n_miss++;
      $display("FAIL idle_st_nack: got n=%b, required 1", bus.O_St_BTk.n);
    end
    bus.I_St_Req = 1'b0;
    $display("reset checks done");
  endtask

  task automatic test_boot();
    push_boot_expect();
    @(posedge clock); #1;
    bus.I_Boot = 1'b1;
    @(negedge clock);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      bus.I_Boot = 1'b0;
      @(negedge clock);
      n_vec++;
      if (k <= 8 && (bus.O_Ld_FTk.v !== 1'b1 || bus.O_Boot !== 1'b1)) begin
        n_miss++;
        $display("FAIL boot_cycle%0d: got v=%b boot=%b, required v=1 boot=1", k, bus.O_Ld_FTk.v, bus.O_Boot);
      end else if (k == 9 && (bus.O_Ld_FTk.v !== 1'b0 || bus.O_Boot !== 1'b0)) begin
        n_miss++;
        $display("FAIL boot_end: got v=%b boot=%b, required v=0 boot=0", bus.O_Ld_FTk.v, bus.O_Boot);
      end
    end
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL boot_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_boot_nack();
    pulse_reset();
    push_boot_expect();
    @(posedge clock); #1;
    bus.I_Boot = 1'b1;
    @(negedge clock);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      bus.I_Boot = 1'b0;
      bus.I_Ld_BTk.n = (k >= 4 && k <= 7);
      @(negedge clock);
      if (k == 7) begin
        n_vec++;
        if (bus.O_Ld_FTk.v !== 1'b1 || bus.O_Ld_FTk.d !== 32'h11) begin
          n_miss++;
          $display("FAIL nack_hold: got v=%b d=%h, required v=1 d=00000011", bus.O_Ld_FTk.v, bus.O_Ld_FTk.d);
        end
      end
    end
    bus.I_Ld_BTk.n = 1'b0;
    for (int k = 0; k < 30 && (exp_q.size() != 0 || bus.O_Boot !== 1'b0); k++) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0 || bus.O_Boot !== 1'b0) begin
      n_miss++;
      $display("FAIL nack_drain: got %0d outstanding boot=%b, required 0 and 0", exp_q.size(), bus.O_Boot);
    end
  endtask

  task automatic test_load_stream();
    exp_t e;
    int   issued = 0;
    logic req;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clock); #1;
      req = (issued < 4);
      bus.I_Ld_Req  = req;
      bus.I_Ld_Addr = 32'(10 + issued);
      @(negedge clock);
      if (req) begin
        n_vec++;
        if (bus.O_Mem_En !== 1'b1 || bus.O_Mem_We !== 1'b0 || bus.O_Mem_Addr !== 10'(10 + issued)) begin
          n_miss++;
          $display("FAIL ld_accept%0d: got en=%b we=%b addr=%0d, required 1 0 %0d",
                   cyc, bus.O_Mem_En, bus.O_Mem_We, bus.O_Mem_Addr, 10 + issued);
        end else begin
          e.d = 32'hA0 + 32'(issued); e.i = 32'(10 + issued); e.a = 1'b0;
          exp_q.push_back(e);
          issued++;
        end
      end
      if (cyc >= 2 && cyc <= 5) begin
        n_vec++;
        if (bus.O_Ld_FTk.v !== 1'b1 || bus.O_Ld_FTk.d !== 32'hA0 + 32'(cyc - 2)) begin
          n_miss++;
          $display("FAIL ld_stream%0d: got v=%b d=%h, required v=1 d=%h",
                   cyc, bus.O_Ld_FTk.v, bus.O_Ld_FTk.d, 32'hA0 + 32'(cyc - 2));
        end
      end
    end
    bus.I_Ld_Req = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL ld_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_store_load();
    exp_t e;
    FTk_t st;
    st = '0; st.v = 1'b1; st.d = 32'hDEAD;
    @(posedge clock); #1;
    bus.I_St_Req = 1'b1; bus.I_St_Addr = 32'd7; bus.I_St_FTk = st;
    @(negedge clock);
    n_vec++;
    if (bus.O_St_BTk.n !== 1'b0 || bus.O_Mem_We !== 1'b1 || bus.O_Mem_Addr !== 10'd7
        || bus.O_Mem_WData !== 32'hDEAD) begin
      n_miss++;
      $display("FAIL st_write: got n=%b we=%b addr=%0d wd=%h, required 0 1 7 0000dead",
               bus.O_St_BTk.n, bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData);
    end
    @(posedge clock); #1;
    bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = 32'd7;
    @(negedge clock);
    n_vec++;
    if (bus.O_Mem_En !== 1'b1 || bus.O_Mem_We !== 1'b0 || bus.O_Mem_Addr !== 10'd7) begin
      n_miss++;
      $display("FAIL st_ld_accept: got en=%b we=%b addr=%0d, required 1 0 7", bus.O_Mem_En, bus.O_Mem_We, bus.O_Mem_Addr);
    end else begin
      e.d = 32'hDEAD; e.i = 32'd7; e.a = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    bus.I_Ld_Req = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL st_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    FTk_t st;
    st = '0; st.v = 1'b1; st.d = 32'hBEEF;
    @(posedge clock); #1;
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = 32'd20;
    bus.I_St_Req = 1'b1; bus.I_St_Addr = 32'd21; bus.I_St_FTk = st;
    @(negedge clock);
    n_vec++;
    if (bus.O_St_BTk.n !== 1'b1 || bus.O_Mem_We !== 1'b0 || bus.O_Mem_Addr !== 10'd20) begin
      n_miss++;
      $display("FAIL cf_priority: got n=%b we=%b addr=%0d, required 1 0 20", bus.O_St_BTk.n, bus.O_Mem_We, bus.O_Mem_Addr);
    end else begin
      e.d = 32'h2020; e.i = 32'd20; e.a = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    bus.I_Ld_Req = 1'b0;
    @(negedge clock);
    n_vec++;
    if (bus.O_St_BTk.n !== 1'b0 || bus.O_Mem_We !== 1'b1 || bus.O_Mem_Addr !== 10'd21) begin
      n_miss++;
      $display("FAIL cf_retry: got n=%b we=%b addr=%0d, required 0 1 21", bus.O_St_BTk.n, bus.O_Mem_We, bus.O_Mem_Addr);
    end
    @(posedge clock); #1;
    bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = 32'd21;
    @(negedge clock);
    n_vec++;
    if (bus.O_Mem_En !== 1'b1 || bus.O_Mem_Addr !== 10'd21) begin
      n_miss++;
      $display("FAIL cf_reload: got en=%b addr=%0d, required 1 21", bus.O_Mem_En, bus.O_Mem_Addr);
    end else begin
      e.d = 32'hBEEF; e.i = 32'd21; e.a = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    bus.I_Ld_Req = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL cf_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midboot();
    exp_t e;
    pulse_reset();
    push_boot_expect();
    @(posedge clock); #1;
    bus.I_Boot = 1'b1;
    @(negedge clock);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); #1;
      bus.I_Boot = 1'b0;
      @(negedge clock);
    end
    @(posedge clock); #2;
    reset = 1'b1;
    bus.I_St_Req = 1'b1;
    #1;
    n_vec++;
    if (bus.O_Boot !== 1'b0 || bus.O_Ld_FTk !== '0 || bus.O_St_BTk !== '0
        || bus.O_Mem_En !== 1'b0 || bus.O_Mem_Addr !== '0) begin
      n_miss++;
      $display("FAIL mid_reset: got boot=%b tok=%h btk=%h en=%b addr=%h, required all 0",
               bus.O_Boot, bus.O_Ld_FTk, bus.O_St_BTk, bus.O_Mem_En, bus.O_Mem_Addr);
    end
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    bus.I_St_Req = 1'b0;
    test_boot();
    @(posedge clock); #1;
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = 32'd1030;
    @(negedge clock);
    n_vec++;
    if (bus.O_Mem_En !== 1'b1 || bus.O_Mem_Addr !== 10'd6) begin
      n_miss++;
      $display("FAIL wrap_addr: got en=%b addr=%0d, required 1 6", bus.O_Mem_En, bus.O_Mem_Addr);
    end else begin
      e.d = 32'h66; e.i = 32'd1030; e.a = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    bus.I_Ld_Req = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL wrap_drain: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.I_Boot     = 1'b0;
    bus.I_Ld_Req   = 1'b0;
    bus.I_Ld_Addr  = '0;
    bus.I_Ld_BTk   = '0;
    bus.I_St_Req   = 1'b0;
    bus.I_St_Addr  = '0;
    bus.I_St_FTk   = '0;
    fork
      sb_monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "timeout");
      end
    join_none

    test_reset();
    for (int k = 0; k < 5; k++) preload(k, cfg_words[k]);
    for (int k = 0; k < 4; k++) preload(10 + k, 32'hA0 + 32'(k));
    preload(6, 32'h66);
    preload(7, 32'h77);
    preload(20, 32'h2020);
    preload(21, 32'h2121);

    test_boot();
    test_boot_nack();
    test_load_stream();
    test_store_load();
    test_conflict();
    test_reset_midboot();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ext_mem_bridge.md
# ext_mem_bridge

Synthesizable external-memory bridge between the ElectronNest top-level load/store ports and a single-port, 1-cycle-latency BRAM. It runs the boot stream, then serves load and store traffic.
- Boot stream: padding tokens with Acq on the first word, followed by the configuration words from BRAM.
- Run mode: turns `Ld_Req`/`Ld_Addr` into forward tokens and writes store tokens into BRAM.
- Backpressure: honours the `n` (nack) field of the backward tokens in both directions.

It replaces the behavioural memory model used in simulation so the full system can be built on FPGA.

## Interface
Parameters:
- `DEPTH_MEM`, default 1024: BRAM words; the address is taken modulo `DEPTH_MEM` (`$clog2` low bits).
- `BOOT_PAD`, default 3: zero-data padding tokens at boot start.
- `BOOT_LEN`, default 5: configuration words streamed from BRAM addresses `0..BOOT_LEN-1`.

Ports (`WIDTH_DATA`, `WIDTH_EXADDR`, `FTk_t`, `BTk_t` from `pkg_en`):
- `clock`  in  1  system clock. One clock domain; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `I_Boot`  in  1  boot start pulse.
- `O_Boot`  out  1  boot strobe to ElectronNest `I_Boot`.
- `I_Ld_Req`  in  1  load request.
- `I_Ld_Addr`  in  `WIDTH_EXADDR`  load address.
- `O_Ld_FTk`  out  `FTk_t`  load data token.
- `I_Ld_BTk`  in  `BTk_t`  load backward token; only `n` is used.
- `I_St_Req`  in  1  store request.
- `I_St_Addr`  in  `WIDTH_EXADDR`  store address.
- `I_St_FTk`  in  `FTk_t`  store data token.
- `O_St_BTk`  out  `BTk_t`  store backward token; only `n` is driven, other fields are 0.
- `O_Mem_En`  out  1  BRAM enable.
- `O_Mem_We`  out  1  BRAM write enable.
- `O_Mem_Addr`  out  `$clog2(DEPTH_MEM)`  BRAM address.
- `O_Mem_WData`  out  `WIDTH_DATA`  BRAM write data.
- `I_Mem_RData`  in  `WIDTH_DATA`  BRAM read data, valid one cycle after the address.

## Operation
- **FSM states:** IDLE, PAD, CFG, RUN.
- **Reset:** state IDLE, FIFO empty, all counters 0. All outputs 0: `O_Boot`=0, `O_Ld_FTk`='0, `O_St_BTk.n`=0, `O_Mem_*`=0.
  - Reset asserted mid-boot or mid-traffic aborts immediately. In-flight reads and FIFO contents are discarded.
- **IDLE:** `I_Boot`=1 moves to PAD and sets `O_Boot`=1. In every other state `I_Boot` is ignored.
- **PAD:** pushes `BOOT_PAD` tokens into the output FIFO: v=1, d=0, i=0, r=c=0.
  - The first pad token carries a=1; all others a=0.
  - During the last PAD cycle, issue the BRAM read of address 0.
- **CFG:** pushes the `BOOT_LEN` words at BRAM addresses 0..`BOOT_LEN-1` as tokens with v=1, a=0.
  - After the last word is pushed: `O_Boot`=0, go to RUN.
- **RUN, load:** `I_Ld_Req` is accepted when (FIFO occupancy + in-flight reads) < 2.
  - On acceptance: BRAM read of `I_Ld_Addr` issued that cycle; the data is pushed next cycle with v=1, a=r=c=0, d=read data, i=address.
  - While a request is not accepted, the requester holds `I_Ld_Req`/`I_Ld_Addr` stable.
- **RUN, store:** a write occurs when `I_St_Req` & `I_St_FTk.v`, no load is accepted that cycle, and the state is RUN.
  - Otherwise `O_St_BTk.n`=1 (combinational) and the store is retried by the sender.
  - Load has priority over store on the single BRAM port.
  - `O_St_BTk.n`=1 in every state other than RUN whenever `I_St_Req`=1.
- **Output FIFO:** depth 2, shared by boot and load tokens. Head drives `O_Ld_FTk`; when empty, `O_Ld_FTk.v`=0.
  - The head pops on any cycle with `I_Ld_BTk.n`=0; with `n`=1 the head is held unchanged.
  - Boot pushes stall while the FIFO is full. PAD/CFG counters advance only on a push, so no word is lost.
- **Address width:** `WIDTH_EXADDR` addresses are truncated to the low `$clog2(DEPTH_MEM)` bits, so the address wraps.

## Timing
- `I_Boot` high in cycle t:
  - `O_Boot`=1 from t+1.
  - Pad tokens visible in cycles t+1..t+`BOOT_PAD` (no nack).
  - Config tokens visible in the following `BOOT_LEN` cycles.
  - `O_Boot`=0 and RUN in the cycle after the last config token is presented.
- Load accepted in cycle t: `O_Mem_En`=1, `O_Mem_Addr` valid in t; token v=1 on `O_Ld_FTk` in t+2.
- With no nack, sustained throughput is one load per cycle.
- Store: `O_Mem_We`=1 in the same cycle as the accepted store. A load issued the next cycle to the same address returns the new data.
- `I_Ld_BTk.n`=1 for k cycles: the token stays on the port for k extra cycles, and at most 2 tokens are buffered.

## Test plan
- **Boot:** BRAM[0..4]=0x11,0x22,0x33,0x44,0x55, pulse `I_Boot`, no nack -> tokens 0(a=1),0,0,0x11..0x55 on 8 consecutive cycles; `O_Boot` falls after 0x55; then v=0.
- **Boot with nack:** same as boot, with `I_Ld_BTk.n`=1 for 4 cycles during CFG -> identical token sequence, no duplicates or drops.
- **Load stream:** `I_Ld_Req` every cycle, addr 10..13 holding 0xA0..0xA3 -> tokens with those values on 4 consecutive cycles starting 2 cycles after the first request; i=10..13.
- **Store then load:** store 0xDEAD to addr 7 -> `O_St_BTk.n`=0; a load of 7 next cycle returns 0xDEAD.
- **Conflict:** `I_Ld_Req` and a store in the same cycle -> load served, `O_St_BTk.n`=1; the store is written the following cycle; load data is correct.
- **Reset:** assert `reset` during CFG -> all outputs 0 within the same cycle; a fresh `I_Boot` replays the full boot sequence; addr 1030 with `DEPTH_MEM`=1024 reads BRAM[6].
